// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/forwarding controller; define HAZARD_STATS_EN for stall/flush counters
module hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter bit ZERO_REG    = 1'b1,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] RA1E,
  input  logic [REG_AW-1:0] RA2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemToRegE,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic              PCSrcM,
  input  logic              PCSrcW,
  input  logic              BranchTakenE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              MemErr,
  output logic [1:0]        State
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]       StallCycles,
  output logic [15:0]       FlushEvents
`endif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO     = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] S_RUN      = 2'b00;
  localparam logic [1:0] S_PC_PEND  = 2'b01;
  localparam logic [1:0] S_MEM_WAIT = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_err_q, mem_err_d;
  logic          rst_q;
  logic          in_reset;
  logic          ld_use;
  logic          pc_pend;
  logic [1:0]    fwd_a, fwd_b;
  logic          va1e, va2e, vwa3e;

  // The cycle after CLR drops still presents reset-like outputs
  assign in_reset = CLR | rst_q;

  // Register 0 is never a real producer/consumer when it is hardwired
  assign va1e  = !(ZERO_REG && (RA1E == '0));
  assign va2e  = !(ZERO_REG && (RA2E == '0));
  assign vwa3e = !(ZERO_REG && (WA3E == '0));

  // Operand bypass select: the younger M result wins over W
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (RegWriteM && (WA3M == RA1E) && va1e)      fwd_a = 2'b10;
    else if (RegWriteW && (WA3W == RA1E) && va1e) fwd_a = 2'b01;
    if (RegWriteM && (WA3M == RA2E) && va2e)      fwd_b = 2'b10;
    else if (RegWriteW && (WA3W == RA2E) && va2e) fwd_b = 2'b01;
  end

  assign ld_use  = MemToRegE & RegWriteE & vwa3e & ((WA3E == RA1D) | (WA3E == RA2D));
  assign pc_pend = PCSrcD | PCSrcE | PCSrcM;

  assign ForwardAE = in_reset ? 2'b00 : fwd_a;
  assign ForwardBE = in_reset ? 2'b00 : fwd_b;
  assign State     = in_reset ? S_RUN : state_q;
  assign MemErr    = mem_err_q & ~CLR;

  // Next-state, wait counter and stall/flush decode; memory wait dominates everything
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    if (in_reset) begin
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      state_d   = S_RUN;
      cnt_d     = '0;
      mem_err_d = 1'b0;
    end else if (state_q == S_MEM_WAIT) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      if (MemReadyM) begin
        state_d = pc_pend ? S_PC_PEND : S_RUN;
        cnt_d   = '0;
      end else begin
        if (cnt_q < TMO) cnt_d = cnt_q + CNT_ONE;
        if (cnt_d >= TMO) mem_err_d = 1'b1;
      end
    end else if (MemReqM && !MemReadyM) begin
      // The entry cycle already counts as the first wait cycle
      StallF  = 1'b1;
      StallD  = 1'b1;
      StallE  = 1'b1;
      StallM  = 1'b1;
      state_d = S_MEM_WAIT;
      cnt_d   = CNT_ONE;
    end else begin
      if (pc_pend)                            state_d = S_PC_PEND;
      else if (state_q == S_PC_PEND && PCSrcW) state_d = S_RUN;
      else if (state_q == S_PC_PEND)           state_d = S_PC_PEND;
      else                                     state_d = S_RUN;

      if (BranchTakenE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (ld_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else if (pc_pend) begin
        StallF = 1'b1;
        FlushD = 1'b1;
      end else if (state_q == S_PC_PEND && PCSrcW) begin
        FlushD = 1'b1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q   <= S_RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
      rst_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
      rst_q     <= 1'b0;
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating event counters; reset cycles never count as flush events
  always_ff @(posedge CLK) begin
    if (CLR) begin
      StallCycles <= '0;
      FlushEvents <= '0;
    end else begin
      if (StallF && StallCycles != 16'hFFFF) StallCycles <= StallCycles + 16'd1;
      if (FlushE && !rst_q && FlushEvents != 16'hFFFF) FlushEvents <= FlushEvents + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int TMO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       CLR;
  logic [4:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteE, RegWriteM, RegWriteW, MemToRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE, State;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles, flush_events;
`endif

  hazard_ctrl #(.REG_AW(5), .ZERO_REG(1'b1), .MEM_TIMEOUT(TMO)) dut (
    .CLK(clk), .CLR(CLR),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .MemErr(MemErr), .State(State)
`ifdef HAZARD_STATS_EN
    ,
    .StallCycles(stall_cycles), .FlushEvents(flush_events)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a waiting flag, a pending-PC flag, a wait-cycle tally
  bit m_wait = 1'b0, m_pend = 1'b0, m_err = 1'b0, m_after_rst = 1'b0;
  int m_waits = 0;

  function automatic logic [1:0] exp_fwd(input logic [4:0] ra);
    if (ra == 0) return 2'b00;
    if (RegWriteM && WA3M == ra) return 2'b10;
    if (RegWriteW && WA3W == ra) return 2'b01;
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    logic [5:0] ev;
    logic [1:0] efa, efb, est;
    logic eerr, lu, pp, blocked;
    if (cmp_en) begin
      lu = MemToRegE && RegWriteE && WA3E != 0 && (WA3E == RA1D || WA3E == RA2D);
      pp = PCSrcD || PCSrcE || PCSrcM;
      blocked = m_wait || (MemReqM && !MemReadyM);
      if (CLR || m_after_rst) begin
        ev = 6'b000011; efa = 2'b00; efb = 2'b00; est = 2'd0; eerr = 1'b0;
      end else begin
        efa = exp_fwd(RA1E);
        efb = exp_fwd(RA2E);
        est = m_wait ? 2'd2 : (m_pend ? 2'd1 : 2'd0);
        eerr = m_err;
        if (blocked)                ev = 6'b111100;
        else if (BranchTakenE)      ev = 6'b000011;
        else if (lu)                ev = 6'b110001;
        else if (pp)                ev = 6'b100010;
        else if (m_pend && PCSrcW)  ev = 6'b000010;
        else                        ev = 6'b000000;
      end
      chk("ctl", {2'b00, StallF, StallD, StallE, StallM, FlushD, FlushE}, {2'b00, ev});
      chk("fwd_a", {6'b0, ForwardAE}, {6'b0, efa});
      chk("fwd_b", {6'b0, ForwardBE}, {6'b0, efb});
      chk("state", {6'b0, State}, {6'b0, est});
      chk("mem_err", {7'b0, MemErr}, {7'b0, eerr});
      // Advance the model to what must hold after the coming rising edge
      if (CLR) begin
        m_wait = 0; m_pend = 0; m_err = 0; m_waits = 0; m_after_rst = 1;
      end else if (m_after_rst) begin
        m_after_rst = 0;
      end else if (m_wait) begin
        if (MemReadyM) begin
          m_wait = 0; m_waits = 0; m_pend = pp;
        end else begin
          m_waits++;
          if (m_waits >= TMO) m_err = 1;
        end
      end else if (MemReqM && !MemReadyM) begin
        m_wait = 1; m_waits = 1; m_pend = 0;
      end else if (pp) begin
        m_pend = 1;
      end else if (m_pend && PCSrcW) begin
        m_pend = 0;
      end
    end
  end

  task automatic idle();
    RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemToRegE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0;
    BranchTakenE = 0; MemReqM = 0; MemReadyM = 1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  initial begin
    CLR = 1; idle();
    tick(); cmp_en = 1;
    look();
    chk("rst_flushd", {7'b0, FlushD}, 8'd1);
    chk("rst_flushe", {7'b0, FlushE}, 8'd1);
    chk("rst_state", {6'b0, State}, 8'd0);
    tick(); CLR = 0;
    look();
    chk("post_rst_flush", {6'b0, FlushD, FlushE}, 8'b11);
    chk("post_rst_stall", {4'b0, StallF, StallD, StallE, StallM}, 8'd0);
    tick();

    // Forwarding priority and register zero
    RA1E = 3; WA3M = 3; RegWriteM = 1; WA3W = 3; RegWriteW = 1;
    look(); chk("fwd_m_prio", {6'b0, ForwardAE}, 8'b10); tick();
    RegWriteM = 0;
    look(); chk("fwd_w", {6'b0, ForwardAE}, 8'b01); tick();
    RA1E = 0; WA3M = 0; WA3W = 0; RegWriteM = 1;
    look(); chk("fwd_zero", {6'b0, ForwardAE}, 8'b00); tick();
    idle();

    // Load-use bubble, then clean cycle
    MemToRegE = 1; RegWriteE = 1; WA3E = 5; RA2D = 5;
    look(); chk("lduse", {2'b0, StallF, StallD, StallE, StallM, FlushD, FlushE}, 8'b110001); tick();
    idle();
    look(); chk("lduse_after", {2'b0, StallF, StallD, StallE, StallM, FlushD, FlushE}, 8'b000000); tick();

    // Branch overrides load-use
    MemToRegE = 1; RegWriteE = 1; WA3E = 5; RA2D = 5; BranchTakenE = 1;
    look(); chk("branch_ovr", {2'b0, StallF, StallD, StallE, StallM, FlushD, FlushE}, 8'b000011); tick();
    idle();

    // PC write walking D, E, M, W
    PCSrcD = 1;
    look(); chk("pc_d", {5'b0, StallF, FlushD, State == 2'd0}, 8'b111); tick();
    PCSrcD = 0; PCSrcE = 1;
    look(); chk("pc_e", {5'b0, StallF, State}, 8'b101); tick();
    PCSrcE = 0; PCSrcM = 1;
    look(); chk("pc_m", {5'b0, StallF, State}, 8'b101); tick();
    PCSrcM = 0; PCSrcW = 1;
    look(); chk("pc_w", {4'b0, StallF, FlushD, State}, 8'b0101); tick();
    PCSrcW = 0;
    look(); chk("pc_done", {6'b0, State}, 8'd0); tick();

    // Short memory wait
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 5; i++) begin
      look();
      chk("mw_stall", {4'b0, StallF, StallD, StallE, StallM}, 8'b1111);
      if (i > 0) chk("mw_state", {6'b0, State}, 8'd2);
      tick();
    end
    MemReadyM = 1;
    look(); chk("mw_ready", {6'b0, State}, 8'd2); tick();
    idle();
    look(); chk("mw_exit", {6'b0, State}, 8'd0); tick();

    // Timeout
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < TMO; i++) begin
      look();
      if (i == TMO - 1) chk("tmo_not_yet", {7'b0, MemErr}, 8'd0);
      tick();
    end
    look(); chk("tmo_err", {5'b0, MemErr, State}, 8'b110); tick();
    MemReadyM = 1; tick();
    idle();
    repeat (3) tick();
    look(); chk("tmo_sticky", {5'b0, MemErr, State}, 8'b100); tick();

    // Reset in the middle of a memory wait
    MemReqM = 1; MemReadyM = 0;
    repeat (3) tick();
    CLR = 1;
    look(); chk("clr_mw", {2'b0, StallF, StallD, StallE, StallM, FlushD, FlushE}, 8'b000011); tick();
    CLR = 0; idle();
    look();
    chk("clr_mw_after", {5'b0, MemErr, State}, 8'd0);
    chk("clr_mw_ctl", {2'b0, StallF, StallD, StallE, StallM, FlushD, FlushE}, 8'b000011);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      CLR          = ($urandom_range(0, 199) == 0);
      RA1D         = 5'($urandom_range(0, 3));
      RA2D         = 5'($urandom_range(0, 3));
      RA1E         = 5'($urandom_range(0, 3));
      RA2E         = 5'($urandom_range(0, 3));
      WA3E         = 5'($urandom_range(0, 3));
      WA3M         = 5'($urandom_range(0, 3));
      WA3W         = 5'($urandom_range(0, 3));
      RegWriteE    = 1'($urandom_range(0, 1));
      RegWriteM    = 1'($urandom_range(0, 1));
      RegWriteW    = 1'($urandom_range(0, 1));
      MemToRegE    = ($urandom_range(0, 2) == 0);
      PCSrcD       = ($urandom_range(0, 6) == 0);
      PCSrcE       = ($urandom_range(0, 6) == 0);
      PCSrcM       = ($urandom_range(0, 6) == 0);
      PCSrcW       = ($urandom_range(0, 3) == 0);
      BranchTakenE = ($urandom_range(0, 7) == 0);
      MemReqM      = ($urandom_range(0, 3) == 0);
      MemReadyM    = ($urandom_range(0, 9) < 6);
      tick();
    end
    CLR = 0; idle();
    tick();
    cmp_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and forwarding controller for the 5-stage pipelined CPU. It is the control end of the D→E pipeline-register interface.
- Consumes the E-stage register addresses and write-enables that the D/E register produces, plus M/W stage write info.
- Drives forwarding selects and the stall/flush (CLR) lines back into the F/D, D/E and E/M registers.
- Contains an FSM that sequences PC-write pending and multi-cycle memory-wait freezes.

Parameters:
REG_AW, 5, register address width
ZERO_REG, 1, 1 = address 0 is hardwired: never forwarded, never causes a hazard
MEM_TIMEOUT, 64, maximum MEM_WAIT cycles before MemErr is raised (≥2)

Ports:
CLK  in  1  clock, rising edge
CLR  in  1  synchronous active-high reset
RA1D, RA2D  in  REG_AW  source registers of the instruction in D
RA1E, RA2E  in  REG_AW  source registers in E
WA3E, WA3M, WA3W  in  REG_AW  destination registers in E/M/W
RegWriteE, RegWriteM, RegWriteW  in  1  register write enables per stage
MemToRegE  in  1  instruction in E is a load
PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  instruction writes the PC, per stage
BranchTakenE  in  1  branch resolved taken in E
MemReqM  in  1  memory access active in M
MemReadyM  in  1  data memory ready
ForwardAE, ForwardBE  out  2  operand select: 00 = register file, 01 = W result, 10 = M ALU result
StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
FlushD, FlushE  out  1  drive the CLR of F/D and D/E
MemErr  out  1  sticky memory-timeout flag
State  out  2  FSM state, for debug

Behaviour:
- Clocking and reset
  - All state updates on the rising CLK edge. CLR is sampled synchronously.
  - While CLR=1 and in the first cycle after it: State=RUN (00), MemErr=0, wait counter=0, ForwardAE/BE=00, all Stall*=0, FlushD=FlushE=1.
  - CLR asserted mid-operation aborts any state immediately at the next edge. No partial completion.
- Forwarding (combinational, every state)
  - ForwardAE = 10 if RegWriteM & WA3M==RA1E & valid(RA1E).
  - Else 01 if RegWriteW & WA3W==RA1E & valid(RA1E).
  - Else 00.
  - ForwardBE uses the same rule with RA2E.
  - valid(x) = ~(ZERO_REG & x==0).
  - M takes priority over W when both match.
- Hazard terms (combinational)
  - LdUse = MemToRegE & RegWriteE & valid(WA3E) & (WA3E==RA1D | WA3E==RA2D).
  - PCPend = PCSrcD | PCSrcE | PCSrcM.
- FSM states: RUN=00, PC_PEND=01, MEM_WAIT=10. Code 11 is illegal and returns to RUN.
- MEM_WAIT has top priority.
  - Entered from any state when MemReqM & ~MemReadyM.
  - While in MEM_WAIT: StallF=StallD=StallE=StallM=1, FlushD=FlushE=0. The wait counter increments each cycle.
  - Exit on MemReadyM=1 to PC_PEND if PCPend, else RUN. The counter clears on exit.
  - If the counter reaches MEM_TIMEOUT: MemErr:=1 (sticky until CLR), and the FSM stays in MEM_WAIT.
- RUN/PC_PEND, when not entering MEM_WAIT:
  - BranchTakenE=1: FlushD=1, FlushE=1, no stalls. This overrides LdUse and PCPend in the same cycle.
  - Else LdUse=1: StallF=StallD=1, FlushE=1 (one bubble). LdUse clears naturally next cycle.
  - Else PCPend=1: StallF=1, FlushD=1, and the FSM goes to (or stays in) PC_PEND.
  - PC_PEND → RUN on PCSrcW=1 with PCPend=0. In that cycle FlushD=1 and StallF=0.
  - StallE and StallM are 0 outside MEM_WAIT.
- Combination rules
  - LdUse and PCPend together: the LdUse outputs apply, and the state transition to PC_PEND still occurs.
  - BranchTakenE together with PCSrcW: FlushD=FlushE=1.

Optional Feature:
- HAZARD_STATS_EN defined adds outputs StallCycles [15:0] and FlushEvents [15:0].
  - Both clear on CLR and saturate at 16'hFFFF.
  - StallCycles increments in every cycle where StallF=1.
  - FlushEvents increments once per cycle where FlushE=1, excluding reset cycles.
- Undefined: the ports do not exist and no counter logic is generated.

Test Plan:
- Forwarding priority: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 → ForwardAE=10. Then RegWriteM=0 → ForwardAE=01. Then RA1E=0 with ZERO_REG=1 → 00.
- Load-use: MemToRegE=1, RegWriteE=1, WA3E=5, RA2D=5 → exactly one cycle of StallF=StallD=1, FlushE=1. The next cycle with no hazard → all 0.
- Branch override: BranchTakenE=1 together with LdUse → FlushD=FlushE=1, StallF=0.
- PC write: PCSrcD=1 for 1 cycle, propagating through E, M, W → State=01 for 3 cycles with StallF=1. The PCSrcW cycle gives FlushD=1 and State=00 next.
- Memory wait: MemReqM=1, MemReadyM=0 for 5 cycles → State=10, all Stall*=1. MemReadyM=1 → RUN. Holding MemReadyM=0 for 64 cycles → MemErr=1 and it stays 1 until CLR.
- Reset mid-MEM_WAIT: assert CLR → next cycle State=00, MemErr=0, FlushD=FlushE=1, Stall*=0.
